// File: rtl/conv_pkg.sv
// Shared constants and types for the 112-sample / 49-tap streaming convolution.
package conv_pkg;

    localparam int unsigned N   = 112;
    localparam int unsigned M   = 49;
    localparam int unsigned XW  = 10;
    localparam int unsigned YW  = 26;
    localparam int unsigned NY  = N - M + 1;
    localparam int unsigned PW  = 2 * XW;
    localparam int unsigned XAW = $clog2(N);
    localparam int unsigned FAW = $clog2(M);
    localparam int unsigned CW  = $clog2(NY);

    typedef logic signed [XW-1:0] sample_t;
    typedef logic signed [YW-1:0] acc_t;
    typedef logic signed [PW-1:0] prod_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_LOAD    = 2'd0;
    localparam state_t ST_COMPUTE = 2'd1;
    localparam state_t ST_OUTPUT  = 2'd2;

endpackage

// File: rtl/conv_mem.sv
// Single-port sample store: synchronous write, combinational read on the same address.
module conv_mem #(
    parameter int unsigned DEPTH = 112,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write only on an accepted transfer; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/conv_112_49.sv
// Streaming valid convolution: loads 112 x and 49 f, then emits 64 results one at a time.
module conv_112_49
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    x_data,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [9:0]    f_data,
    input  logic          f_valid,
    output logic          f_ready,
    output logic [25:0]   y_data,
    output logic          y_valid,
    input  logic          y_ready
);

    state_t         state_q, state_d;
    logic [XAW-1:0] x_cnt_q, x_cnt_d;
    logic [FAW-1:0] f_cnt_q, f_cnt_d;
    logic [CW-1:0]  m_q, m_d;
    logic [FAW-1:0] n_q, n_d;
    acc_t           acc_q, acc_d;
    acc_t           y_data_q, y_data_d;
    logic           y_valid_q, y_valid_d;
    logic           x_ready_q, x_ready_d;
    logic           f_ready_q, f_ready_d;

    logic           x_fire, f_fire;
    logic [XAW-1:0] x_addr;
    logic [FAW-1:0] f_addr;
    sample_t        x_rd, f_rd;
    prod_t          prod;

    assign x_fire = x_valid & x_ready_q;
    assign f_fire = f_valid & f_ready_q;

    // Memories share their port between loading (count address) and compute (tap address).
    assign x_addr = (state_q == ST_COMPUTE) ? (XAW'(m_q) + XAW'(n_q)) : x_cnt_q;
    assign f_addr = (state_q == ST_COMPUTE) ? n_q : f_cnt_q;

    conv_mem #(.DEPTH(N), .WIDTH(XW)) u_x_mem (
        .clk   (clk),
        .we    (x_fire),
        .addr  (x_addr),
        .wdata (x_data),
        .rdata (x_rd)
    );

    conv_mem #(.DEPTH(M), .WIDTH(XW)) u_f_mem (
        .clk   (clk),
        .we    (f_fire),
        .addr  (f_addr),
        .wdata (f_data),
        .rdata (f_rd)
    );

    assign prod = prod_t'(x_rd) * prod_t'(f_rd);

    // Next-state, counters, MAC and output register.
    always_comb begin
        state_d   = state_q;
        x_cnt_d   = x_cnt_q;
        f_cnt_d   = f_cnt_q;
        m_d       = m_q;
        n_d       = n_q;
        acc_d     = acc_q;
        y_data_d  = y_data_q;
        y_valid_d = y_valid_q;
        x_ready_d = 1'b0;
        f_ready_d = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (x_fire) begin
                    x_cnt_d = x_cnt_q + XAW'(1);
                end
                if (f_fire) begin
                    f_cnt_d = f_cnt_q + FAW'(1);
                end
                if ((x_cnt_d == XAW'(N)) && (f_cnt_d == FAW'(M))) begin
                    state_d = ST_COMPUTE;
                    m_d     = '0;
                    n_d     = '0;
                end
            end
            ST_COMPUTE: begin
                acc_d = ((n_q == '0) ? acc_t'(0) : acc_q) + acc_t'(prod);
                if (n_q == FAW'(M - 1)) begin
                    y_data_d  = acc_d;
                    y_valid_d = 1'b1;
                    n_d       = '0;
                    state_d   = ST_OUTPUT;
                end else begin
                    n_d = n_q + FAW'(1);
                end
            end
            ST_OUTPUT: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    if (m_q == CW'(NY - 1)) begin
                        m_d     = '0;
                        x_cnt_d = '0;
                        f_cnt_d = '0;
                        state_d = ST_LOAD;
                    end else begin
                        m_d     = m_q + CW'(1);
                        state_d = ST_COMPUTE;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Ready is registered and looks ahead at next state/count, so it never follows valid.
        x_ready_d = (state_d == ST_LOAD) && (x_cnt_d < XAW'(N));
        f_ready_d = (state_d == ST_LOAD) && (f_cnt_d < FAW'(M));
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            x_cnt_q   <= '0;
            f_cnt_q   <= '0;
            m_q       <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            x_ready_q <= 1'b0;
            f_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_cnt_q   <= x_cnt_d;
            f_cnt_q   <= f_cnt_d;
            m_q       <= m_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            y_data_q  <= y_data_d;
            y_valid_q <= y_valid_d;
            x_ready_q <= x_ready_d;
            f_ready_q <= f_ready_d;
        end
    end

    assign x_ready = x_ready_q;
    assign f_ready = f_ready_q;
    assign y_data  = y_data_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_conv_112_49.sv
// Scoreboard bench for conv_112_49: random flow control, directed vectors, mid-run reset.
module tb_conv_112_49;

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         x_data;
    logic               x_valid;
    logic               x_ready;
    logic [9:0]         f_data;
    logic               f_valid;
    logic               f_ready;
    logic signed [25:0] y_data;
    logic               y_valid;
    logic               y_ready;

    int checks   = 0;
    int failures = 0;
    int sb[$];
    int recv      = 0;
    int exp_v     = 0;
    int in_pct    = 100;
    int ready_pct = 100;

    logic signed [9:0] xv [112];
    logic signed [9:0] fv [49];

    always #5 clk = ~clk;

    conv_112_49 dut (
        .clk     (clk),
        .reset   (reset),
        .x_data  (x_data),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .f_data  (f_data),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    // Monitor: choose y_ready each cycle and compare every accepted result with the queue head.
    always @(negedge clk) begin
        if (reset) begin
            y_ready = 1'b0;
        end else begin
            y_ready = ($urandom_range(99) < ready_pct);
            if (y_valid && y_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_y got=%0d expected=none", int'(y_data));
                end else begin
                    exp_v = sb.pop_front();
                    if (int'(y_data) != exp_v) begin
                        failures++;
                        $display("FAIL y_data out#%0d got=%0d expected=%0d", recv, int'(y_data), exp_v);
                    end
                end
                recv++;
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        x_valid = 1'b0;
        f_valid = 1'b0;
        x_data  = 'x;
        f_data  = 'x;
        sb.delete();
        @(negedge clk);
        chk("reset_x_ready", int'(x_ready), 0);
        chk("reset_f_ready", int'(f_ready), 0);
        chk("reset_y_valid", int'(y_valid), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_x_ready", int'(x_ready), 1);
        chk("post_reset_f_ready", int'(f_ready), 1);
        chk("post_reset_y_valid", int'(y_valid), 0);
    endtask

    // Fill x/f for one iteration and queue the reference results computed from the definition.
    task automatic prepare(input int mode);
        int acc;
        for (int i = 0; i < 112; i++) begin
            case (mode)
                1:       xv[i] = 10'(i - 56);
                2, 3:    xv[i] = -10'sd512;
                default: xv[i] = 10'($urandom);
            endcase
        end
        for (int n = 0; n < 49; n++) begin
            case (mode)
                1:       fv[n] = (n == 0) ? 10'sd1 : 10'sd0;
                2:       fv[n] = -10'sd512;
                3:       fv[n] = 10'sd511;
                default: fv[n] = 10'($urandom);
            endcase
        end
        for (int m = 0; m < 64; m++) begin
            acc = 0;
            for (int n = 0; n < 49; n++) begin
                acc += int'(xv[m + n]) * int'(fv[n]);
            end
            sb.push_back(acc);
        end
    endtask

    task automatic drive_x();
        int i = 0;
        int budget = 0;
        while (i < 112 && budget < 20000) begin
            @(negedge clk);
            budget++;
            if ($urandom_range(99) < in_pct) begin
                x_valid = 1'b1;
                x_data  = xv[i];
                if (x_ready) i++;
            end else begin
                x_valid = 1'b0;
                x_data  = 'x;
            end
        end
        @(negedge clk);
        x_valid = 1'b0;
        x_data  = 'x;
        if (i < 112) begin
            checks++;
            failures++;
            $display("FAIL x_load_timeout got=%0d expected=112", i);
        end
    endtask

    task automatic drive_f();
        int i = 0;
        int budget = 0;
        while (i < 49 && budget < 20000) begin
            @(negedge clk);
            budget++;
            if ($urandom_range(99) < in_pct) begin
                f_valid = 1'b1;
                f_data  = fv[i];
                if (f_ready) i++;
            end else begin
                f_valid = 1'b0;
                f_data  = 'x;
            end
        end
        @(negedge clk);
        f_valid = 1'b0;
        f_data  = 'x;
        if (i < 49) begin
            checks++;
            failures++;
            $display("FAIL f_load_timeout got=%0d expected=49", i);
        end
    endtask

    task automatic load_iter(input int mode);
        recv = 0;
        prepare(mode);
        fork
            drive_x();
            drive_f();
        join
    endtask

    task automatic drain(input int expected_count);
        int budget = 0;
        while (sb.size() != 0 && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d expected=0 pending", sb.size());
            sb.delete();
        end
        chk("result_count", recv, expected_count);
    endtask

    task automatic run_iter(input int mode);
        load_iter(mode);
        drain(64);
    endtask

    initial begin
        int budget;
        reset   = 1'b1;
        x_valid = 1'b0;
        f_valid = 1'b0;
        x_data  = 'x;
        f_data  = 'x;
        y_ready = 1'b0;
        do_reset();

        // Directed vectors, full-rate handshakes, back to back.
        in_pct = 100; ready_pct = 100;
        run_iter(1);
        run_iter(2);
        run_iter(3);
        run_iter(0);

        // Random flow control on all three channels.
        in_pct = 50; ready_pct = 50;
        for (int it = 0; it < 12; it++) begin
            run_iter(0);
        end

        // Reset while computing result 30, then a fresh iteration must yield exactly 64.
        load_iter(0);
        budget = 0;
        while (recv < 30 && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        chk("reached_m30", (recv >= 30) ? 1 : 0, 1);
        repeat (10) @(negedge clk);
        do_reset();
        recv = 0;
        run_iter(0);
        ready_pct = 100;
        repeat (300) @(negedge clk);
        chk("no_stale_outputs", recv, 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
